// File: rtl/lock_pkg.sv
// lock_pkg: definitions shared by the keypad entry controller and the lock.
//   - FSM state encoding for the entry controller
//   - default number of cycles the lock response is sampled
//   - one-hot test used by the key edge detector
package lock_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_COLLECT = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRESENT = 3'd2;
  localparam logic [STATE_W-1:0] ST_CHECK   = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd4;

  localparam int RESULT_CYCLES_DEFAULT = 4;

  // True when exactly one of the four key lines is high.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: turns the raw keypad lines into single-cycle digit strobes.
//   clock  : system clock
//   reset  : asynchronous, active-low reset
//   key    : keypad lines, active-high, synchronous to clock
//   accept : high for one cycle when key is exactly one-hot and was all-zero
//            on the previous cycle
//   digit  : the key value that accompanies accept
// The history register resets to zero, so a key already held when reset is
// released counts as a fresh press.
module key_edge_detect
  import lock_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key,
  output logic       accept,
  output logic [3:0] digit
);

  logic [3:0] key_p0;

  // Stage 0: previous-cycle key history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_p0 <= 4'd0;
    end else begin
      key_p0 <= key;
    end
  end

  // A multi-hot value after a release never qualifies, and neither does the
  // one-hot value that may follow it, because the history is then non-zero.
  assign accept = (key_p0 == 4'd0) && is_one_hot(key);
  assign digit  = key;

endmodule

// File: rtl/keypad_entry_controller.sv
// keypad_entry_controller: collects PASSCODE_LENGTH one-hot keypad digits,
// presents them to the lock, watches the lock's error response and applies a
// lockout after MAX_ATTEMPTS consecutive failures.
//   clock       : system clock
//   reset       : asynchronous, active-low reset
//   key         : keypad lines, active-high
//   entry_ready : lock accepts the presented entry this cycle
//   lock_error  : lock error response, sampled for RESULT_CYCLES cycles
//   entry       : packed one-hot digits, first digit in the MSB nibble
//   entry_valid : entry is being presented to the lock
//   timeout     : one-cycle pulse when a partial entry is discarded
//   lockout     : keys are ignored after repeated failures
//   fail_count  : consecutive failed attempts
module keypad_entry_controller
  import lock_pkg::*;
#(
  parameter int PASSCODE_LENGTH = 3,
  parameter int CLOCK_FREQ      = 50000000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int RESULT_CYCLES   = RESULT_CYCLES_DEFAULT,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 500000000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [3:0]                           key,
  input  logic                                 entry_ready,
  input  logic                                 lock_error,
  output logic [4*PASSCODE_LENGTH-1:0]         entry,
  output logic                                 entry_valid,
  output logic                                 timeout,
  output logic                                 lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    fail_count
);

  localparam int EW     = 4 * PASSCODE_LENGTH;
  localparam int FC_W   = $clog2(MAX_ATTEMPTS + 1);
  localparam int DIG_W  = $clog2(PASSCODE_LENGTH + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RES_W  = $clog2(RESULT_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  // Clock frequency is informational; the timing parameters are in cycles.
  logic unused_params;
  assign unused_params = (CLOCK_FREQ > 0);

  // Counters stop at their limit instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

  logic [STATE_W-1:0] state, state_nx;
  logic [DIG_W-1:0]   dig_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RES_W-1:0]   res_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic               err_seen;

  logic               accept;
  logic [3:0]         digit;
  logic [EW-1:0]      entry_shift;
  logic               last_digit, tmo_hit, res_last, lock_last;
  logic               err_any, fail_hit;
  logic [FC_W-1:0]    fc_inc;

  key_edge_detect u_key_edge_detect (
    .clock  (clock),
    .reset  (reset),
    .key    (key),
    .accept (accept),
    .digit  (digit)
  );

  // New digit enters at the LSB nibble; older digits move toward the MSB.
  always_comb begin
    entry_shift      = entry << 4;
    entry_shift[3:0] = digit;
  end

  // dig_cnt counts digits accepted after the first one.
  assign last_digit = (dig_cnt == DIG_W'(PASSCODE_LENGTH - 2));
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign res_last   = (res_cnt == RES_W'(RESULT_CYCLES - 1));
  assign lock_last  = (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1));
  assign err_any    = err_seen | lock_error;
  assign fc_inc     = FC_W'(sat_inc(32'(fail_count), 32'(MAX_ATTEMPTS)));
  assign fail_hit   = err_any && (fc_inc == FC_W'(MAX_ATTEMPTS));

  assign entry_valid = (state == ST_PRESENT);
  assign lockout     = (state == ST_LOCKOUT);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = (PASSCODE_LENGTH == 1) ? ST_PRESENT : ST_COLLECT;
      end
      ST_COLLECT: begin
        // A digit on the timeout boundary keeps the entry alive.
        if (accept) begin
          if (last_digit) state_nx = ST_PRESENT;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (entry_ready) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (res_last) state_nx = fail_hit ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (lock_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      entry      <= '0;
      timeout    <= 1'b0;
      fail_count <= '0;
      dig_cnt    <= '0;
      tmo_cnt    <= '0;
      res_cnt    <= '0;
      lock_cnt   <= '0;
      err_seen   <= 1'b0;
    end else begin
      state   <= state_nx;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            entry   <= entry_shift;
            dig_cnt <= '0;
            tmo_cnt <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            entry   <= entry_shift;
            dig_cnt <= DIG_W'(sat_inc(32'(dig_cnt), 32'(PASSCODE_LENGTH)));
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            entry   <= '0;
            timeout <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= TMO_W'(sat_inc(32'(tmo_cnt), 32'(TIMEOUT_CYCLES)));
          end
        end
        ST_PRESENT: begin
          if (entry_ready) begin
            res_cnt  <= '0;
            err_seen <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (res_last) begin
            entry      <= '0;
            lock_cnt   <= '0;
            fail_count <= err_any ? fc_inc : '0;
          end else begin
            res_cnt  <= RES_W'(sat_inc(32'(res_cnt), 32'(RESULT_CYCLES)));
            err_seen <= err_any;
          end
        end
        ST_LOCKOUT: begin
          if (lock_last) begin
            entry      <= '0;
            fail_count <= '0;
          end else begin
            lock_cnt <= LOCK_W'(sat_inc(32'(lock_cnt), 32'(LOCKOUT_CYCLES)));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Testbench for keypad_entry_controller: directed scenarios followed by
// randomized key/lock_error traffic, all checked cycle by cycle against a
// queue-based reference model of the entry rules.
module tb_keypad_entry_controller;
  import lock_pkg::*;

  localparam int PL   = 3;
  localparam int TMO  = 20;
  localparam int LOCK = 50;
  localparam int MAXA = 3;
  localparam int RES  = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  key;
  logic        entry_ready;
  logic        lock_error;
  logic [11:0] entry;
  logic        entry_valid;
  logic        timeout;
  logic        lockout;
  logic [1:0]  fail_count;

  keypad_entry_controller #(
    .PASSCODE_LENGTH (PL),
    .TIMEOUT_CYCLES  (TMO),
    .MAX_ATTEMPTS    (MAXA),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .entry_ready (entry_ready),
    .lock_error  (lock_error),
    .entry       (entry),
    .entry_valid (entry_valid),
    .timeout     (timeout),
    .lockout     (lockout),
    .fail_count  (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: digits collected so far live in a queue; the
  // presentation, check window and lockout are modelled as countdowns.
  logic [3:0] m_prev;
  logic [3:0] m_q[$];
  bit         m_presenting;
  int         m_check_left;
  bit         m_err_seen;
  int         m_lock_left;
  int         m_idle_run;
  int         m_fails;
  bit         m_tmo;

  task automatic model_reset();
    m_prev       = 4'd0;
    m_q.delete();
    m_presenting = 1'b0;
    m_check_left = 0;
    m_err_seen   = 1'b0;
    m_lock_left  = 0;
    m_idle_run   = 0;
    m_fails      = 0;
    m_tmo        = 1'b0;
  endtask

  function automatic logic [11:0] m_entry();
    logic [11:0] v;
    v = 12'd0;
    foreach (m_q[i]) v = {v[7:0], m_q[i]};
    return v;
  endfunction

  task automatic model_step(input logic [3:0] k, input logic e);
    bit press;
    press  = (m_prev == 4'd0) && ($countones(k) == 1);
    m_prev = k;
    m_tmo  = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_check_left > 0) begin
      m_err_seen = m_err_seen | e;
      m_check_left--;
      if (m_check_left == 0) begin
        m_q.delete();
        if (m_err_seen) begin
          if (m_fails < MAXA) m_fails++;
          if (m_fails == MAXA) m_lock_left = LOCK;
        end else begin
          m_fails = 0;
        end
      end
    end else if (m_presenting) begin
      // entry_ready is always 1 here, so presentation lasts one cycle
      m_presenting = 1'b0;
      m_check_left = RES;
      m_err_seen   = 1'b0;
    end else if (press) begin
      m_q.push_back(k);
      m_idle_run = 0;
      if (m_q.size() == PL) m_presenting = 1'b1;
    end else if (m_q.size() != 0) begin
      m_idle_run++;
      if (m_idle_run >= TMO) begin
        m_q.delete();
        m_tmo = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("entry",       32'(entry),       32'(m_entry()));
    check_eq("entry_valid", 32'(entry_valid), 32'(m_presenting));
    check_eq("timeout",     32'(timeout),     32'(m_tmo));
    check_eq("lockout",     32'(lockout),     32'(m_lock_left > 0));
    check_eq("fail_count",  32'(fail_count),  32'(m_fails));
  endtask

  // One clock: drive at the falling edge, step the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input logic [3:0] k, input logic e);
    key        = k;
    lock_error = e;
    @(posedge clock);
    model_step(k, e);
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    repeat (hold) cycle(k, 1'b0);
    repeat (gap) cycle(4'd0, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input logic e);
    repeat (n) cycle(4'd0, e);
  endtask

  function automatic logic [3:0] rand_one_hot();
    return 4'(4'b0001 << $urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rand_key();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 4'd0;
    if (r < 8) return rand_one_hot();
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, tmo_at, n;
    reset       = 1'b0;
    key         = 4'd0;
    lock_error  = 1'b0;
    entry_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);

    check_eq("rst_entry",   32'(entry),       32'h0);
    check_eq("rst_valid",   32'(entry_valid), 32'h0);
    check_eq("rst_timeout", 32'(timeout),     32'h0);
    check_eq("rst_lockout", 32'(lockout),     32'h0);
    check_eq("rst_fails",   32'(fail_count),  32'h0);
    reset = 1'b1;

    // Basic three-digit entry accepted by the lock
    press(4'b0001, 1, 1);
    press(4'b0100, 1, 1);
    cycle(4'b1000, 1'b0);
    check_eq("s1_entry", 32'(entry),       32'h148);
    check_eq("s1_valid", 32'(entry_valid), 32'h1);
    cycle(4'd0, 1'b0);
    check_eq("s1_valid_drop", 32'(entry_valid), 32'h0);
    idle_cycles(RES + 2, 1'b0);
    check_eq("s1_fails", 32'(fail_count), 32'h0);

    // Partial entry abandoned until the timeout fires
    press(4'b0010, 1, 1);
    cycle(4'b0001, 1'b0);
    pulses = 0;
    tmo_at = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle(4'd0, 1'b0);
      if (timeout) begin
        pulses++;
        tmo_at = i;
      end
    end
    check_eq("s2_pulses", 32'(pulses), 32'd1);
    check_eq("s2_tmo_at", 32'(tmo_at), 32'd20);
    check_eq("s2_entry",  32'(entry),  32'h0);
    check_eq("s2_state",  32'(dut.state), 32'(ST_IDLE));

    // Three rejected entries lead to lockout
    for (int a = 1; a <= MAXA; a++) begin
      press(4'b0001, 1, 1);
      press(4'b0010, 1, 1);
      press(4'b0100, 1, 1);
      idle_cycles(RES, 1'b1);
      check_eq("s3_fails", 32'(fail_count), 32'(a));
    end
    check_eq("s3_lockout_rise", 32'(lockout), 32'h1);
    n = 0;
    while (lockout && n < 200) begin
      cycle((n % 2 == 0) ? rand_one_hot() : 4'd0, 1'b0);
      n++;
    end
    check_eq("s3_lockout_len", 32'(n), 32'd50);
    check_eq("s3_fails_clr",   32'(fail_count), 32'h0);
    check_eq("s3_entry_clr",   32'(entry), 32'h0);

    // Multi-hot press is ignored, next one-hot press is the first digit
    press(4'b0011, 1, 1);
    press(4'b0100, 1, 1);
    check_eq("s4_first", 32'(entry), 32'h004);
    press(4'b0001, 1, 1);
    cycle(4'b0010, 1'b0);
    check_eq("s4_entry", 32'(entry), 32'h412);
    check_eq("s4_valid", 32'(entry_valid), 32'h1);
    idle_cycles(RES + 2, 1'b0);

    // Reset in the middle of an entry
    press(4'b1000, 1, 1);
    press(4'b0010, 1, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("s5_entry",   32'(entry),       32'h0);
    check_eq("s5_valid",   32'(entry_valid), 32'h0);
    check_eq("s5_timeout", 32'(timeout),     32'h0);
    check_eq("s5_lockout", 32'(lockout),     32'h0);
    check_eq("s5_fails",   32'(fail_count),  32'h0);
    check_eq("s5_state",   32'(dut.state),   32'(ST_IDLE));
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    press(4'b0001, 1, 1);
    press(4'b0100, 1, 1);
    cycle(4'b0010, 1'b0);
    check_eq("s5_entry_after", 32'(entry), 32'h142);
    check_eq("s5_valid_after", 32'(entry_valid), 32'h1);
    idle_cycles(RES + 2, 1'b0);

    // Randomized traffic: full entries with random lock responses mixed
    // with raw key noise
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        bit err_entry;
        err_entry = ($urandom_range(0, 2) != 0);
        for (int d = 0; d < PL; d++)
          press(rand_one_hot(), $urandom_range(1, 2), $urandom_range(1, 3));
        for (int c = 0; c < RES + 1; c++)
          cycle(4'd0, err_entry && ($urandom_range(0, 2) == 0));
      end else begin
        int len;
        len = $urandom_range(5, 30);
        for (int c = 0; c < len; c++)
          cycle(rand_key(), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_controller.md
KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

Interface
REQ-001 The module SHALL have parameter PASSCODE_LENGTH, default 3: digits per entry.
REQ-002 The module SHALL have parameter CLOCK_FREQ, default 50000000: clock frequency in Hz (documentation only).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 250000000: idle cycles allowed between digits.
REQ-004 The module SHALL have parameter RESULT_CYCLES, default 4: cycles the lock response is sampled.
REQ-005 The module SHALL have parameter MAX_ATTEMPTS, default 3: consecutive failures that trigger lockout.
REQ-006 The module SHALL have parameter LOCKOUT_CYCLES, default 500000000: lockout duration in cycles.
REQ-007 The module SHALL have port clock, input, 1 bit: the single clock.
REQ-008 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The module SHALL have port key, input, 4 bits: keypad, active-high, synchronous to clock.
REQ-010 The module SHALL have port entry_ready, input, 1 bit: the lock accepts entry this cycle.
REQ-011 The module SHALL have port lock_error, input, 1 bit: the lock's error output.
REQ-012 The module SHALL have port entry, output, 4*PASSCODE_LENGTH bits: packed one-hot digits; first digit in the MSB nibble.
REQ-013 The module SHALL have port entry_valid, output, 1 bit: entry is presented to the lock.
REQ-014 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when a partial entry is discarded.
REQ-015 The module SHALL have port lockout, output, 1 bit: high while keys are ignored after repeated failures.
REQ-016 The module SHALL have port fail_count, output, $clog2(MAX_ATTEMPTS+1) bits: consecutive failures.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, PRESENT, CHECK and LOCKOUT.
REQ-018 A digit SHALL be accepted only on the first cycle on which key is exactly one-hot after a cycle on which key was 0; zero-to-multi-hot transitions SHALL be ignored.
REQ-019 Accepted digits SHALL be shifted into entry from the LSB end, so after PASSCODE_LENGTH digits the first digit occupies the MSB nibble.
REQ-020 In IDLE, the first accepted digit SHALL move the FSM to COLLECT and clear the digit counter and timeout counter.
REQ-021 In COLLECT, each accepted digit SHALL increment the digit counter and clear the timeout counter.
REQ-022 In COLLECT, acceptance of digit PASSCODE_LENGTH SHALL move the FSM to PRESENT on the next cycle.
REQ-023 In COLLECT, if the timeout counter reaches TIMEOUT_CYCLES with no new digit, the controller SHALL clear entry, pulse timeout for one cycle, and return to IDLE.
REQ-024 If a digit and the timeout boundary occur on the same cycle, the digit SHALL win.
REQ-025 In PRESENT, entry_valid SHALL be 1 and entry SHALL be held stable; keys SHALL be ignored.
REQ-026 The controller SHALL go to CHECK on the cycle after entry_valid and entry_ready are both 1; entry_valid SHALL then drop.
REQ-027 In CHECK, lock_error SHALL be sampled for RESULT_CYCLES cycles.
REQ-028 If lock_error is seen during CHECK, fail_count SHALL increment; the FSM SHALL go to LOCKOUT if the new value equals MAX_ATTEMPTS, otherwise to IDLE.
REQ-029 If lock_error is not seen during CHECK, fail_count SHALL be cleared and the FSM SHALL return to IDLE.
REQ-030 In LOCKOUT, lockout SHALL be 1 and keys SHALL be ignored; after LOCKOUT_CYCLES the controller SHALL clear fail_count, drop lockout and enter IDLE.
REQ-031 The controller SHALL clear entry on every entry to IDLE.
REQ-032 The counters SHALL saturate and never wrap.

Reset
REQ-033 Asserting reset (low) SHALL immediately force IDLE, entry=0, entry_valid=0, timeout=0, lockout=0, fail_count=0 and clear all counters, including from mid-entry or LOCKOUT.
REQ-034 The key edge-detect history SHALL reset to 0, so a key already held at reset release counts as a press.

Structure
REQ-035 The FSM state encoding and the RESULT_CYCLES default SHALL live in a shared package, lock_pkg, also used by the lock.
REQ-036 The design SHALL contain one sub-module, key_edge_detect, which produces the one-hot accept pulse and the 4-bit digit.
REQ-037 The rest of the design SHALL be a single clocked process plus next-state logic.

Verification
REQ-038 The bench SHALL use overrides TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=50, MAX_ATTEMPTS=3 and entry_ready tied to 1.
REQ-039 Scenario: keys 0001, 0100, 1000, each high 1 cycle and low 1 cycle -> entry=12'h148, entry_valid high for 1 cycle, fail_count stays 0.
REQ-040 Scenario: keys 0010 then 0001, then 25 idle cycles -> timeout pulses once after cycle 20 since the last digit, entry=0, state IDLE.
REQ-041 Scenario: three full entries, each answered with lock_error=1 -> fail_count goes 1, 2, 3; lockout rises; keys pressed during lockout are ignored; lockout falls after 50 cycles with fail_count=0.
REQ-042 Scenario: key=0011 pressed, then 0100 -> the first press is ignored and only 0100 counts as digit 1.
REQ-043 Scenario: reset driven low mid-collect after 2 digits -> all outputs are 0 immediately; the next 3-digit entry completes normally.
